// File: rtl/axis_to_vdma_adapter.sv
// axis_to_vdma_adapter: converts an AXI4-Stream RGB565 pixel stream into the
// VDMA video-input strobes (vs_n / de / data).
//
// Each frame is repaired to exactly H_ACTIVE x V_ACTIVE pixels:
//   - short lines are padded with PAD_PIXEL
//   - long lines are truncated
//
// The stream's tready is a pure decode of registered state. Because of that,
// a start-of-frame beat cannot be refused on the cycle it is presented.
// Instead it is accepted and parked in a holding register. After the vsync
// pulse it is replayed as pixel 0 of the new frame from the FIRST state.
module axis_to_vdma_adapter #(
    parameter int          H_ACTIVE  = 800,
    parameter int          V_ACTIVE  = 480,
    parameter int          VS_PULSE  = 16,
    parameter logic [15:0] PAD_PIXEL = 16'h0000
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        enable,
    input  logic [15:0] s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic        s_tlast,
    input  logic        s_tuser,
    output logic        vin_vs_n,
    output logic        vin_de,
    output logic [15:0] vin_data,
    output logic        err_short,
    output logic        err_long,
    output logic        err_sof,
    output logic [15:0] frame_count
);

    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int VW = (VS_PULSE > 1) ? $clog2(VS_PULSE) : 1;
    localparam logic [XW-1:0] X_LAST  = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VS_LAST = VW'(VS_PULSE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_FIRST,
        ST_ACTIVE,
        ST_PAD,
        ST_DROP
    } state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [VW-1:0] vs_cnt_q, vs_cnt_d;
    logic [15:0]   sof_data_q, sof_data_d;
    logic          sof_last_q, sof_last_d;
    logic          run_q;
    logic          vin_vs_n_q, vin_vs_n_d;
    logic          vin_de_q, vin_de_d;
    logic [15:0]   vin_data_q, vin_data_d;
    logic          err_short_q, err_short_d;
    logic          err_long_q, err_long_d;
    logic          err_sof_q, err_sof_d;
    logic [15:0]   frame_count_q, frame_count_d;

    logic          beat, sof_start, sof_restart, pix_fire, pix_last;
    logic          x_end, y_end, line_short, line_long, vs_done, eol;
    logic [15:0]   pix_data;

    // Decode this cycle's events, shared by next-state and datapath logic.
    // FIRST replays the parked SOF beat as if it had just been accepted.
    always_comb begin
        beat        = s_tvalid & s_tready;
        x_end       = (x_q == X_LAST);
        y_end       = (y_q == Y_LAST);
        vs_done     = (state_q == ST_VSYNC) && (vs_cnt_q == VS_LAST);
        sof_start   = beat && s_tuser && (state_q == ST_IDLE) && enable;
        sof_restart = beat && s_tuser &&
                      (((state_q == ST_ACTIVE) && ((x_q != '0) || (y_q != '0))) ||
                       (state_q == ST_DROP));
        pix_fire    = ((state_q == ST_ACTIVE) && beat && !sof_restart) ||
                      (state_q == ST_FIRST);
        pix_data    = (state_q == ST_FIRST) ? sof_data_q : s_tdata;
        pix_last    = (state_q == ST_FIRST) ? sof_last_q : s_tlast;
        line_short  = pix_fire && pix_last && !x_end;
        line_long   = pix_fire && !pix_last && x_end;
        eol         = (pix_fire && pix_last && x_end) ||
                      ((state_q == ST_PAD) && x_end) ||
                      ((state_q == ST_DROP) && beat && s_tlast && !sof_restart);
    end

    // Next-state logic; a start of frame wins over every other event.
    always_comb begin
        state_d = state_q;
        if (sof_start || sof_restart) begin
            state_d = ST_VSYNC;
        end else begin
            case (state_q)
                ST_VSYNC: if (vs_done) state_d = ST_FIRST;
                ST_FIRST,
                ST_ACTIVE,
                ST_PAD,
                ST_DROP: begin
                    if (eol)             state_d = y_end ? ST_IDLE : ST_ACTIVE;
                    else if (line_short) state_d = ST_PAD;
                    else if (line_long)  state_d = ST_DROP;
                    else if (state_q == ST_FIRST) state_d = ST_ACTIVE;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Counters, SOF holding register and next values of the registered outputs.
    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        vs_cnt_d      = vs_cnt_q;
        sof_data_d    = sof_data_q;
        sof_last_d    = sof_last_q;
        vin_vs_n_d    = (state_d != ST_VSYNC);
        vin_de_d      = 1'b0;
        vin_data_d    = vin_data_q;
        err_short_d   = 1'b0;
        err_long_d    = 1'b0;
        err_sof_d     = sof_restart;
        frame_count_d = frame_count_q;

        if (sof_start || sof_restart) begin
            x_d        = '0;
            y_d        = '0;
            vs_cnt_d   = '0;
            sof_data_d = s_tdata;
            sof_last_d = s_tlast;
        end

        if ((state_q == ST_VSYNC) && !vs_done) begin
            vs_cnt_d = vs_cnt_q + 1'b1;
        end

        if (pix_fire) begin
            vin_de_d    = 1'b1;
            vin_data_d  = pix_data;
            err_short_d = line_short;
            err_long_d  = line_long;
            if (!x_end) x_d = x_q + 1'b1;
        end

        if (state_q == ST_PAD) begin
            vin_de_d   = 1'b1;
            vin_data_d = PAD_PIXEL;
            if (!x_end) x_d = x_q + 1'b1;
        end

        if (eol) begin
            x_d = '0;
            if (y_end) begin
                y_d           = '0;
                frame_count_d = frame_count_q + 16'd1;
            end else begin
                y_d = y_q + 1'b1;
            end
        end
    end

    // Ready is decoded from registers only; run_q keeps it low while in reset.
    always_comb begin
        s_tready = run_q && ((state_q == ST_IDLE) || (state_q == ST_ACTIVE) ||
                             (state_q == ST_DROP));
    end

    // State and output registers; reset aborts any frame in progress at once.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q       <= ST_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            vs_cnt_q      <= '0;
            sof_data_q    <= '0;
            sof_last_q    <= 1'b0;
            run_q         <= 1'b0;
            vin_vs_n_q    <= 1'b1;
            vin_de_q      <= 1'b0;
            vin_data_q    <= '0;
            err_short_q   <= 1'b0;
            err_long_q    <= 1'b0;
            err_sof_q     <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            vs_cnt_q      <= vs_cnt_d;
            sof_data_q    <= sof_data_d;
            sof_last_q    <= sof_last_d;
            run_q         <= 1'b1;
            vin_vs_n_q    <= vin_vs_n_d;
            vin_de_q      <= vin_de_d;
            vin_data_q    <= vin_data_d;
            err_short_q   <= err_short_d;
            err_long_q    <= err_long_d;
            err_sof_q     <= err_sof_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign vin_vs_n    = vin_vs_n_q;
    assign vin_de      = vin_de_q;
    assign vin_data    = vin_data_q;
    assign err_short   = err_short_q;
    assign err_long    = err_long_q;
    assign err_sof     = err_sof_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_axis_to_vdma_adapter.sv
// Testbench for axis_to_vdma_adapter with a 4x2 frame and a 3-cycle vsync.
//
// Expected pixels (data plus short/long error flags) are queued as each
// scenario is driven. A monitor pops one entry for every vin_de it sees.
module tb_axis_to_vdma_adapter;

    typedef struct packed {
        logic [15:0] data;
        logic        es;
        logic        el;
    } exp_t;

    logic        hclk = 1'b0;
    logic        hreset = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic        s_tuser = 1'b0;
    logic        vin_vs_n;
    logic        vin_de;
    logic [15:0] vin_data;
    logic        err_short;
    logic        err_long;
    logic        err_sof;
    logic [15:0] frame_count;

    int   errors = 0;
    int   checks = 0;
    int   de_cnt = 0;
    int   vs_pulses = 0;
    int   vs_low = 0;
    int   sof_cnt = 0;
    exp_t exp_q[$];

    axis_to_vdma_adapter #(
        .H_ACTIVE (4),
        .V_ACTIVE (2),
        .VS_PULSE (3),
        .PAD_PIXEL(16'h0000)
    ) dut (
        .hclk       (hclk),
        .hreset     (hreset),
        .enable     (enable),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_tlast    (s_tlast),
        .s_tuser    (s_tuser),
        .vin_vs_n   (vin_vs_n),
        .vin_de     (vin_de),
        .vin_data   (vin_data),
        .err_short  (err_short),
        .err_long   (err_long),
        .err_sof    (err_sof),
        .frame_count(frame_count)
    );

    // 10 ns clock
    always #5 hclk = ~hclk;

    // Watchdog so a stuck run still ends with a report
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: scoreboard pops on vin_de, vsync pulse widths, err_sof pulses
    always @(negedge hclk) begin
        if (!hreset) begin
            if (vin_de) begin
                de_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    assert (1'b0) else begin
                        errors++;
                        $error("[TB] FAIL unexpected_de observed=%0h expected=none", vin_data);
                    end
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    assert ({vin_data, err_short, err_long} === {e.data, e.es, e.el}) else begin
                        errors++;
                        $error("[TB] FAIL pixel observed=%0h/%0b/%0b expected=%0h/%0b/%0b",
                               vin_data, err_short, err_long, e.data, e.es, e.el);
                    end
                end
            end
            if (err_sof) sof_cnt++;
            if (!vin_vs_n) begin
                vs_low++;
            end else if (vs_low != 0) begin
                checks++;
                assert (vs_low === 3) else begin
                    errors++;
                    $error("[TB] FAIL vs_width observed=%0d expected=3", vs_low);
                end
                vs_pulses++;
                vs_low = 0;
            end
        end
    end

    task automatic push_expected(input logic [15:0] d, input logic es, input logic el);
        exp_t e;
        e.data = d;
        e.es   = es;
        e.el   = el;
        exp_q.push_back(e);
    endtask

    // Present one beat and hold it until the DUT accepts it (bounded)
    task automatic applyStimulus(input logic [15:0] d, input logic u, input logic l);
        bit got;
        got      = 1'b0;
        s_tdata  = d;
        s_tuser  = u;
        s_tlast  = l;
        s_tvalid = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge hclk);
            if (s_tready) got = 1'b1;
        end
        if (got) begin
            @(posedge hclk);
            #1;
        end else begin
            checks++;
            errors++;
            $error("[TB] FAIL handshake observed=no_ready expected=accept data=%0h", d);
        end
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
    endtask

    // Wait (bounded) until every queued pixel has been seen, then settle
    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge hclk);
            n++;
        end
        checkOutput({tag, "_drain"}, exp_q.size(), 0);
        repeat (3) @(posedge hclk);
        #1;
    endtask

    initial begin
        int de0, vs0, sof0;

        // Reset state
        #22;
        checkOutput("rst_vs_n",   vin_vs_n, 1);
        checkOutput("rst_de",     vin_de, 0);
        checkOutput("rst_data",   vin_data, 0);
        checkOutput("rst_tready", s_tready, 0);
        checkOutput("rst_errs",   {err_short, err_long, err_sof}, 0);
        checkOutput("rst_fc",     frame_count, 0);
        @(posedge hclk);
        #1;
        hreset = 1'b0;
        enable = 1'b1;

        // Nominal frame: 1..8, tlast on 4 and 8
        de0 = de_cnt; vs0 = vs_pulses; sof0 = sof_cnt;
        for (int i = 1; i <= 8; i++) push_expected(16'(i), 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) applyStimulus(16'(i), i == 1, (i == 4) || (i == 8));
        wait_drain("nominal");
        checkOutput("nominal_fc",  frame_count, 1);
        checkOutput("nominal_de",  de_cnt - de0, 8);
        checkOutput("nominal_vs",  vs_pulses - vs0, 1);
        checkOutput("nominal_sof", sof_cnt - sof0, 0);

        // Short line: line 0 has 2 beats, then two pad pixels
        de0 = de_cnt;
        push_expected(16'h0011, 1'b0, 1'b0);
        push_expected(16'h0012, 1'b1, 1'b0);
        push_expected(16'h0000, 1'b0, 1'b0);
        push_expected(16'h0000, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) push_expected(16'h0020 + 16'(i), 1'b0, 1'b0);
        applyStimulus(16'h0011, 1'b1, 1'b0);
        applyStimulus(16'h0012, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) applyStimulus(16'h0020 + 16'(i), 1'b0, i == 4);
        wait_drain("short");
        checkOutput("short_fc", frame_count, 2);
        checkOutput("short_de", de_cnt - de0, 8);

        // Long line: 6 beats, the last two dropped
        de0 = de_cnt;
        for (int i = 1; i <= 4; i++) push_expected(16'h0030 + 16'(i), 1'b0, i == 4);
        for (int i = 1; i <= 4; i++) push_expected(16'h0040 + 16'(i), 1'b0, 1'b0);
        for (int i = 1; i <= 6; i++) applyStimulus(16'h0030 + 16'(i), i == 1, i == 6);
        for (int i = 1; i <= 4; i++) applyStimulus(16'h0040 + 16'(i), 1'b0, i == 4);
        wait_drain("long");
        checkOutput("long_fc", frame_count, 3);
        checkOutput("long_de", de_cnt - de0, 8);

        // Mid-frame SOF on the 3rd beat; that beat restarts the frame as pixel 0
        de0 = de_cnt; vs0 = vs_pulses; sof0 = sof_cnt;
        push_expected(16'h0051, 1'b0, 1'b0);
        push_expected(16'h0052, 1'b0, 1'b0);
        for (int i = 3; i <= 6; i++) push_expected(16'h0050 + 16'(i), 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) push_expected(16'h0060 + 16'(i), 1'b0, 1'b0);
        applyStimulus(16'h0051, 1'b1, 1'b0);
        applyStimulus(16'h0052, 1'b0, 1'b0);
        for (int i = 3; i <= 6; i++) applyStimulus(16'h0050 + 16'(i), i == 3, i == 6);
        for (int i = 1; i <= 4; i++) applyStimulus(16'h0060 + 16'(i), 1'b0, i == 4);
        wait_drain("midsof");
        checkOutput("midsof_sof", sof_cnt - sof0, 1);
        checkOutput("midsof_vs",  vs_pulses - vs0, 2);
        checkOutput("midsof_de",  de_cnt - de0, 10);
        checkOutput("midsof_fc",  frame_count, 4);

        // Enable low: whole frame consumed, nothing emitted
        enable = 1'b0;
        de0 = de_cnt; vs0 = vs_pulses;
        for (int i = 1; i <= 8; i++) applyStimulus(16'h0070 + 16'(i), i == 1, (i == 4) || (i == 8));
        repeat (8) @(posedge hclk);
        #1;
        checkOutput("enlow_de", de_cnt - de0, 0);
        checkOutput("enlow_vs", vs_pulses - vs0, 0);
        checkOutput("enlow_vs_n", vin_vs_n, 1);
        checkOutput("enlow_fc", frame_count, 4);
        enable = 1'b1;

        // Reset after pixel 5, then a clean frame
        for (int i = 1; i <= 5; i++) push_expected(16'h0090 + 16'(i), 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) applyStimulus(16'h0090 + 16'(i), i == 1, i == 4);
        wait_drain("prereset");
        hreset = 1'b1;
        #1;
        checkOutput("midrst_vs_n",   vin_vs_n, 1);
        checkOutput("midrst_de",     vin_de, 0);
        checkOutput("midrst_data",   vin_data, 0);
        checkOutput("midrst_tready", s_tready, 0);
        checkOutput("midrst_fc",     frame_count, 0);
        @(posedge hclk);
        #1;
        hreset = 1'b0;
        de0 = de_cnt;
        for (int i = 1; i <= 8; i++) push_expected(16'h00A0 + 16'(i), 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) applyStimulus(16'h00A0 + 16'(i), i == 1, (i == 4) || (i == 8));
        wait_drain("postrst");
        checkOutput("postrst_fc", frame_count, 1);
        checkOutput("postrst_de", de_cnt - de0, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
